// File: rtl/snake_controller_if.sv
// Control/status bundle between the snake sequencing controller and its user
// (buttons and length select in, ring-datapath strobes and display status out).
interface snake_controller_if;
    logic        btn_run;
    logic        btn_dir;
    logic        btn_faster;
    logic        btn_slower;
    logic [1:0]  len_sel;
    logic        step_en;
    logic        step_dir;
    logic        load;
    logic [11:0] load_pattern;
    logic [2:0]  speed;
    logic        running;
    logic        blank;

    modport master (
        output btn_run, btn_dir, btn_faster, btn_slower, len_sel,
        input  step_en, step_dir, load, load_pattern, speed, running, blank
    );

    modport slave (
        input  btn_run, btn_dir, btn_faster, btn_slower, len_sel,
        output step_en, step_dir, load, load_pattern, speed, running, blank
    );
endinterface

// File: rtl/snake_controller.sv
// Sequencing controller for the 12-bit snake ring: step timing, direction,
// pattern loads, run/pause FSM, saturating speed level and pause blinking.
module snake_controller #(
    parameter int unsigned BASE_DIV  = 1000,
    parameter int unsigned BLINK_DIV = 5000
) (
    input  logic              clock,
    input  logic              reset,
    snake_controller_if.slave bus
);
    localparam int unsigned PW = $clog2(8 * BASE_DIV);
    localparam int unsigned BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

    localparam logic [1:0] ST_INIT  = 2'd0;
    localparam logic [1:0] ST_LOAD  = 2'd1;
    localparam logic [1:0] ST_RUN   = 2'd2;
    localparam logic [1:0] ST_PAUSE = 2'd3;

    logic [1:0]    state_q, state_d;
    logic [1:0]    ret_q, ret_d;
    logic [1:0]    len_q, len_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [BW-1:0] blink_q, blink_d;
    logic          step_en_q, step_en_d;
    logic          step_dir_q, step_dir_d;
    logic          load_q, load_d;
    logic [11:0]   pattern_q, pattern_d;
    logic [2:0]    speed_q, speed_d;
    logic          running_q, running_d;
    logic          blank_q, blank_d;

    logic [PW-1:0] period_last_s;
    logic          active_s;
    logic          len_chg_s;
    logic          spd_up_s;
    logic          spd_dn_s;

    function automatic logic [11:0] pattern_for(input logic [1:0] len);
        logic [11:0] pat;
        case (len)
            2'd0:    pat = 12'h800;
            2'd1:    pat = 12'hC00;
            2'd2:    pat = 12'hE00;
            2'd3:    pat = 12'hF00;
            default: pat = 12'hE00;
        endcase
        return pat;
    endfunction

    assign period_last_s = PW'(BASE_DIV * (32'd8 - 32'(speed_q)) - 32'd1);
    assign active_s      = (state_q == ST_RUN) || (state_q == ST_PAUSE);
    assign len_chg_s     = (bus.len_sel != len_q);
    assign spd_up_s      = active_s && bus.btn_faster && !bus.btn_slower && (speed_q != 3'd7);
    assign spd_dn_s      = active_s && bus.btn_slower && !bus.btn_faster && (speed_q != 3'd0);

    // Next-state logic for the FSM, prescaler, blink timer and all output registers.
    always_comb begin
        state_d    = state_q;
        ret_d      = ret_q;
        len_d      = len_q;
        presc_d    = presc_q;
        blink_d    = {BW{1'b0}};
        blank_d    = 1'b0;
        step_en_d  = 1'b0;
        load_d     = 1'b0;
        pattern_d  = pattern_q;
        speed_d    = speed_q;
        step_dir_d = step_dir_q ^ (bus.btn_dir && (state_q != ST_INIT));
        case (state_q)
            ST_INIT: begin
                len_d     = bus.len_sel;
                pattern_d = pattern_for(bus.len_sel);
                load_d    = 1'b1;
                ret_d     = ST_RUN;
                state_d   = ST_LOAD;
            end
            ST_LOAD: begin
                presc_d = {PW{1'b0}};
                state_d = ret_q;
            end
            ST_RUN: begin
                if (presc_q == period_last_s) begin
                    presc_d   = {PW{1'b0}};
                    step_en_d = 1'b1;
                end else begin
                    presc_d = presc_q + PW'(1);
                end
                // A length change wins over btn_run in the same cycle.
                if (len_chg_s) begin
                    len_d     = bus.len_sel;
                    pattern_d = pattern_for(bus.len_sel);
                    load_d    = 1'b1;
                    ret_d     = ST_RUN;
                    state_d   = ST_LOAD;
                end else if (bus.btn_run) begin
                    state_d = ST_PAUSE;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_PAUSE: begin
                if (len_chg_s) begin
                    len_d     = bus.len_sel;
                    pattern_d = pattern_for(bus.len_sel);
                    load_d    = 1'b1;
                    ret_d     = ST_PAUSE;
                    state_d   = ST_LOAD;
                end else if (bus.btn_run) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_PAUSE;
                    if (blink_q == BLINK_LAST) begin
                        blink_d = {BW{1'b0}};
                        blank_d = ~blank_q;
                    end else begin
                        blink_d = blink_q + BW'(1);
                        blank_d = blank_q;
                    end
                end
            end
            default: begin
                state_d = ST_INIT;
            end
        endcase
        // A real speed change restarts the step period and suppresses this cycle's step.
        if (spd_up_s) begin
            speed_d   = speed_q + 3'd1;
            presc_d   = {PW{1'b0}};
            step_en_d = 1'b0;
        end else if (spd_dn_s) begin
            speed_d   = speed_q - 3'd1;
            presc_d   = {PW{1'b0}};
            step_en_d = 1'b0;
        end else begin
            speed_d = speed_q;
        end
        running_d = (state_d == ST_RUN);
    end

    // State and output registers with asynchronous active-low reset.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_INIT;
            ret_q      <= ST_RUN;
            len_q      <= 2'd2;
            presc_q    <= {PW{1'b0}};
            blink_q    <= {BW{1'b0}};
            step_en_q  <= 1'b0;
            step_dir_q <= 1'b0;
            load_q     <= 1'b0;
            pattern_q  <= 12'hE00;
            speed_q    <= 3'd3;
            running_q  <= 1'b0;
            blank_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            ret_q      <= ret_d;
            len_q      <= len_d;
            presc_q    <= presc_d;
            blink_q    <= blink_d;
            step_en_q  <= step_en_d;
            step_dir_q <= step_dir_d;
            load_q     <= load_d;
            pattern_q  <= pattern_d;
            speed_q    <= speed_d;
            running_q  <= running_d;
            blank_q    <= blank_d;
        end
    end

    assign bus.step_en      = step_en_q;
    assign bus.step_dir     = step_dir_q;
    assign bus.load         = load_q;
    assign bus.load_pattern = pattern_q;
    assign bus.speed        = speed_q;
    assign bus.running      = running_q;
    assign bus.blank        = blank_q;
endmodule

// File: doc/snake_controller.md
Name: snake_controller

Overview:
- Sequencing controller for the 12-bit snake ring datapath that drives the two 7-segment displays.
- Generates the step strobe and direction, and issues a pattern load that sets snake length (1-4 lit segments).
- Runs a run/pause state machine from single-cycle button pulses and holds a saturating speed level.
- Datapath rotates only on step_en and replaces its contents on load; this block owns all timing.

Parameters:
BASE_DIV, 1000, clock cycles per speed unit; step period N = BASE_DIV*(8-speed), range 1*BASE_DIV..8*BASE_DIV
BLINK_DIV, 5000, clock cycles between blank toggles while paused

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low; 0 = reset
btn_run  in  1  one-cycle pulse; toggles RUN/PAUSE
btn_dir  in  1  one-cycle pulse; toggles step_dir
btn_faster  in  1  one-cycle pulse; speed+1
btn_slower  in  1  one-cycle pulse; speed-1
len_sel  in  2  snake length minus 1 (0..3 = 1..4 segments)
step_en  out  1  one-cycle rotate strobe to ring datapath
step_dir  out  1  0 = rotate toward LSB, {r[0],r[11:1]}; 1 = toward MSB
load  out  1  one-cycle strobe: datapath takes load_pattern
load_pattern  out  12  top (len+1) bits set, rest 0
speed  out  3  current speed level 0..7
running  out  1  1 while in RUN
blank  out  1  display blanking; blinks in PAUSE only

Behaviour:
- Reset (reset=0, async): state INIT; step_en=0, step_dir=0, load=0, load_pattern=12'b111000000000, speed=3, running=0, blank=0, prescaler=0, latched length=2.
- All outputs are registered. Buttons are already synchronised, one-cycle pulses.
- INIT: one cycle. Latches len_sel and goes to LOAD with return target RUN.
- LOAD: one cycle. load=1 and load_pattern holds the latched length: len 0 -> 12'h800, 1 -> 12'hC00, 2 -> 12'hE00, 3 -> 12'hF00. Clears the prescaler and goes to the return target.
- RUN: running=1. Prescaler counts 0..N-1. On wrap, step_en=1 for one cycle.
  - First step_en is exactly N cycles after the first RUN cycle, then every N cycles.
  - btn_run -> PAUSE. If the wrap falls in the same cycle, step_en is still issued.
- PAUSE: running=0. Prescaler holds its value and step_en=0.
  - blank toggles every BLINK_DIV cycles, starting at 0 on entry.
  - btn_run -> RUN; prescaler resumes from the held value; blank forced 0.
- Length change: in RUN or PAUSE, if len_sel differs from the latched length, latch the new value and go to LOAD with return target = current state. A btn_run in the same cycle is ignored.
- btn_dir: step_dir toggles on the next edge in any state except INIT. A step_en in the same cycle uses the old direction.
- Speed:
  - btn_faster increments, saturating at 7; btn_slower decrements, saturating at 0.
  - Both in the same cycle: no change.
  - Any actual speed change clears the prescaler to 0; no step is issued that cycle.
- Presses during LOAD or INIT: btn_run, btn_faster and btn_slower are dropped. btn_dir is honoured except in INIT.
- Reset asserted mid-operation: everything returns to reset values immediately. After release: INIT, then LOAD, then RUN.
- Prescaler width: ceil(log2(8*BASE_DIV)). Blink counter width: ceil(log2(BLINK_DIV)).

Test Plan:
- BASE_DIV=4, len_sel=2, release reset -> load=1 with 12'hE00 on the 2nd cycle. RUN entered; step_en pulses at RUN cycles 20, 40, 60 (speed 3, N=20). step_dir=0.
- 5x btn_faster -> speed=7, N=4, step_en every 4 cycles. 9x btn_slower -> speed=0, N=32. btn_faster and btn_slower in the same cycle -> speed unchanged, prescaler not cleared.
- btn_run at RUN cycle 10 -> no step_en while paused; blank toggles every BLINK_DIV cycles. btn_run again -> next step_en exactly 10 cycles later.
- btn_dir in the same cycle as step_en -> that step uses step_dir=0; step_dir=1 from the next cycle on.
- len_sel 2->0 while paused -> one-cycle load with 12'h800; state returns to PAUSE with running=0. len_sel 0->3 while running -> load with 12'hF00, then RUN with the prescaler restarting from 0.
- reset pulsed low mid-RUN with speed=6, step_dir=1 -> all outputs return to reset values asynchronously. Sequence restarts with load 12'hE00 (len_sel=2).
